// File: rtl/pong_pkg.sv
// Shared definitions for the pong match sequencer and the game datapath:
// match state encoding, default speed/paddle limits and the helpers that
// turn the difficulty level into ball speed and paddle height.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RALLY = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } pong_state_t;

    localparam int START_SPEED_DEF = 1;
    localparam int MAX_SPEED_DEF   = 4;
    localparam int PADDLE_MAX_DEF  = 100;
    localparam int PADDLE_MIN_DEF  = 25;
    localparam int PADDLE_STEP_DEF = 9;

    // Ball speed: start speed plus one step every four levels, capped.
    function automatic logic [2:0] calc_speed(input logic [3:0] lvl,
                                              input int start_speed,
                                              input int max_speed);
        logic [4:0] raw_s;
        raw_s = 5'(start_speed) + 5'(lvl[3:2]);
        if (raw_s > 5'(max_speed)) begin
            calc_speed = 3'(max_speed);
        end else begin
            calc_speed = 3'(raw_s);
        end
    endfunction

    // Paddle height: shrinks by a fixed step per level, floored at the
    // minimum. Evaluated 11 bits wide so the subtraction never wraps.
    function automatic logic [8:0] calc_paddle(input logic [3:0] lvl,
                                               input int paddle_max,
                                               input int paddle_min,
                                               input int paddle_step);
        logic [10:0] dec_s;
        logic [10:0] max_s;
        logic [10:0] min_s;
        dec_s = 11'(lvl) * 11'(paddle_step);
        max_s = 11'(paddle_max);
        min_s = 11'(paddle_min);
        if ((dec_s + min_s) >= max_s) begin
            calc_paddle = 9'(min_s);
        end else begin
            calc_paddle = 9'(max_s - dec_s);
        end
    endfunction

endpackage

// File: rtl/pong_tick_timer.sv
// Tick-enabled counter: counts enabled cycles from 0 to LIMIT-1, then wraps
// to 0 and raises wrap for that one enabled cycle. clear has priority.
module pong_tick_timer #(
    parameter int LIMIT = 100,
    parameter int WIDTH = $clog2(LIMIT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic wrap
);

    localparam logic [WIDTH-1:0] LAST_C = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_r;
    logic             terminal_s;

    assign terminal_s = (count_r == LAST_C);
    assign wrap       = enable & terminal_s;

    // Counter register: clear, wrap on terminal count, or advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            if (terminal_s) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + WIDTH'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/pong_match_sequencer.sv
// Match sequencer for pong: walks IDLE/SERVE/RALLY/PAUSE/OVER on game ticks,
// keeps score, chooses serve direction and raises difficulty during rallies.
module pong_match_sequencer
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 11,
    parameter int PAUSE_TICKS = 100,
    parameter int LEVEL_TICKS = 1024,
    parameter int MAX_LEVEL   = 8,
    parameter int START_SPEED = START_SPEED_DEF,
    parameter int MAX_SPEED   = MAX_SPEED_DEF,
    parameter int PADDLE_MAX  = PADDLE_MAX_DEF,
    parameter int PADDLE_MIN  = PADDLE_MIN_DEF,
    parameter int PADDLE_STEP = PADDLE_STEP_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       launch,
    input  logic       point_p0,
    input  logic       point_p1,
    output logic       run,
    output logic       round_reset,
    output logic       serve_dir,
    output logic [2:0] ball_speed,
    output logic [8:0] paddle_h,
    output logic [3:0] level,
    output logic [6:0] score_p0,
    output logic [6:0] score_p1,
    output logic       winner_valid,
    output logic       winner
);

    localparam logic [6:0] WIN_SCORE_C = 7'(WIN_SCORE);
    localparam logic [3:0] MAX_LEVEL_C = 4'(MAX_LEVEL);

    pong_state_t state_r, state_nx_s;
    logic [6:0]  score_p0_r, score_p0_nx_s, score_p0_inc_s;
    logic [6:0]  score_p1_r, score_p1_nx_s, score_p1_inc_s;
    logic        serve_dir_r, serve_dir_nx_s;
    logic        winner_valid_r, winner_valid_nx_s;
    logic        winner_r, winner_nx_s;
    logic        flag_p0_r, flag_p1_r;
    logic        hit_p0_s, hit_p1_s;
    logic [3:0]  level_r;
    logic [2:0]  ball_speed_r;
    logic [8:0]  paddle_h_r;
    logic        in_rally_s, in_pause_s;
    logic        serve_entry_s;
    logic        pause_wrap_s, level_wrap_s;

    assign in_rally_s = (state_r == ST_RALLY);
    assign in_pause_s = (state_r == ST_PAUSE);

    // A pulse landing on the tick cycle itself still counts for that tick.
    assign hit_p0_s = flag_p0_r | (point_p0 & in_rally_s);
    assign hit_p1_s = flag_p1_r | (point_p1 & in_rally_s);

    assign score_p0_inc_s = (score_p0_r < WIN_SCORE_C) ? (score_p0_r + 7'd1) : score_p0_r;
    assign score_p1_inc_s = (score_p1_r < WIN_SCORE_C) ? (score_p1_r + 7'd1) : score_p1_r;

    assign serve_entry_s = tick & (state_nx_s == ST_SERVE) & (state_r != ST_SERVE);

    pong_tick_timer #(.LIMIT(PAUSE_TICKS)) u_pause_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (~in_pause_s),
        .enable (tick & in_pause_s),
        .wrap   (pause_wrap_s)
    );

    pong_tick_timer #(.LIMIT(LEVEL_TICKS)) u_level_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (serve_entry_s),
        .enable (tick & in_rally_s),
        .wrap   (level_wrap_s)
    );

    // Sticky point flags: set only during RALLY, consumed on every tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            flag_p0_r <= 1'b0;
            flag_p1_r <= 1'b0;
        end else if (tick) begin
            flag_p0_r <= 1'b0;
            flag_p1_r <= 1'b0;
        end else if (in_rally_s) begin
            flag_p0_r <= flag_p0_r | point_p0;
            flag_p1_r <= flag_p1_r | point_p1;
        end else begin
            flag_p0_r <= 1'b0;
            flag_p1_r <= 1'b0;
        end
    end

    // Next-state and match bookkeeping, evaluated only on tick cycles.
    always_comb begin
        state_nx_s        = state_r;
        score_p0_nx_s     = score_p0_r;
        score_p1_nx_s     = score_p1_r;
        serve_dir_nx_s    = serve_dir_r;
        winner_valid_nx_s = winner_valid_r;
        winner_nx_s       = winner_r;
        if (tick) begin
            case (state_r)
                ST_IDLE: begin
                    state_nx_s = ST_SERVE;
                end
                ST_SERVE: begin
                    if (launch) begin
                        state_nx_s = ST_RALLY;
                    end else begin
                        state_nx_s = ST_SERVE;
                    end
                end
                ST_RALLY: begin
                    if (hit_p0_s && hit_p1_s) begin
                        state_nx_s = ST_PAUSE;
                    end else if (hit_p0_s) begin
                        score_p0_nx_s  = score_p0_inc_s;
                        serve_dir_nx_s = 1'b1;
                        if (score_p0_inc_s == WIN_SCORE_C) begin
                            state_nx_s        = ST_OVER;
                            winner_valid_nx_s = 1'b1;
                            winner_nx_s       = 1'b0;
                        end else begin
                            state_nx_s = ST_PAUSE;
                        end
                    end else if (hit_p1_s) begin
                        score_p1_nx_s  = score_p1_inc_s;
                        serve_dir_nx_s = 1'b0;
                        if (score_p1_inc_s == WIN_SCORE_C) begin
                            state_nx_s        = ST_OVER;
                            winner_valid_nx_s = 1'b1;
                            winner_nx_s       = 1'b1;
                        end else begin
                            state_nx_s = ST_PAUSE;
                        end
                    end else begin
                        state_nx_s = ST_RALLY;
                    end
                end
                ST_PAUSE: begin
                    if (pause_wrap_s) begin
                        state_nx_s = ST_SERVE;
                    end else begin
                        state_nx_s = ST_PAUSE;
                    end
                end
                ST_OVER: begin
                    if (launch) begin
                        state_nx_s        = ST_SERVE;
                        score_p0_nx_s     = 7'd0;
                        score_p1_nx_s     = 7'd0;
                        winner_valid_nx_s = 1'b0;
                        serve_dir_nx_s    = 1'b0;
                    end else begin
                        state_nx_s = ST_OVER;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Match state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            score_p0_r     <= 7'd0;
            score_p1_r     <= 7'd0;
            serve_dir_r    <= 1'b1;
            winner_valid_r <= 1'b0;
            winner_r       <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            score_p0_r     <= score_p0_nx_s;
            score_p1_r     <= score_p1_nx_s;
            serve_dir_r    <= serve_dir_nx_s;
            winner_valid_r <= winner_valid_nx_s;
            winner_r       <= winner_nx_s;
        end
    end

    // Difficulty level: restarts on each serve, steps up per level period.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_r <= 4'd0;
        end else if (serve_entry_s) begin
            level_r <= 4'd0;
        end else if (level_wrap_s && (level_r < MAX_LEVEL_C)) begin
            level_r <= level_r + 4'd1;
        end else begin
            level_r <= level_r;
        end
    end

    // Speed and paddle height follow the level one clock later.
    always_ff @(posedge clock) begin
        if (reset) begin
            ball_speed_r <= 3'(START_SPEED);
            paddle_h_r   <= 9'(PADDLE_MAX);
        end else begin
            ball_speed_r <= calc_speed(level_r, START_SPEED, MAX_SPEED);
            paddle_h_r   <= calc_paddle(level_r, PADDLE_MAX, PADDLE_MIN, PADDLE_STEP);
        end
    end

    assign run          = in_rally_s;
    assign round_reset  = ~in_rally_s;
    assign serve_dir    = serve_dir_r;
    assign ball_speed   = ball_speed_r;
    assign paddle_h     = paddle_h_r;
    assign level        = level_r;
    assign score_p0     = score_p0_r;
    assign score_p1     = score_p1_r;
    assign winner_valid = winner_valid_r;
    assign winner       = winner_r;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Scoreboard bench for pong_match_sequencer: stimulus pushes the expected
// outputs of a rule-level match model; a monitor pops and compares them.
module tb_pong_match_sequencer;

    localparam int WIN = 2;
    localparam int PT  = 100;
    localparam int LT  = 4;
    localparam int ML  = 8;

    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_RALLY = 2;
    localparam int M_PAUSE = 3;
    localparam int M_OVER  = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       launch = 1'b0;
    logic       point_p0 = 1'b0;
    logic       point_p1 = 1'b0;
    logic       run, round_reset, serve_dir, winner_valid, winner;
    logic [2:0] ball_speed;
    logic [8:0] paddle_h;
    logic [3:0] level;
    logic [6:0] score_p0, score_p1;

    pong_match_sequencer #(
        .WIN_SCORE(WIN), .PAUSE_TICKS(PT), .LEVEL_TICKS(LT), .MAX_LEVEL(ML)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick), .launch(launch),
        .point_p0(point_p0), .point_p1(point_p1), .run(run),
        .round_reset(round_reset), .serve_dir(serve_dir),
        .ball_speed(ball_speed), .paddle_h(paddle_h), .level(level),
        .score_p0(score_p0), .score_p1(score_p1),
        .winner_valid(winner_valid), .winner(winner)
    );

    always #5 clock = ~clock;

    typedef struct {
        int run; int rr; int sd; int speed; int paddle; int level;
        int s0; int s1; int wv; int win; int slot;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   slot   = 0;

    // Rule-level model of the match.
    int m_state, m_s0, m_s1, m_sd, m_wv, m_win, m_rally, m_pause, m_f0, m_f1;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_s0 = 0; m_s1 = 0; m_sd = 1; m_wv = 0; m_win = 0;
        m_rally = 0; m_pause = 0; m_f0 = 0; m_f1 = 0;
    endtask

    task automatic enter_serve();
        m_state = M_SERVE;
        m_rally = 0;
    endtask

    task automatic model_tick(input bit l);
        int f0, f1, w, ns;
        f0 = m_f0; f1 = m_f1; m_f0 = 0; m_f1 = 0;
        case (m_state)
            M_IDLE:  enter_serve();
            M_SERVE: if (l) m_state = M_RALLY;
            M_RALLY: begin
                m_rally++;
                if (f0 != 0 && f1 != 0) begin
                    m_state = M_PAUSE; m_pause = 0;
                end else if (f0 != 0 || f1 != 0) begin
                    w = (f0 != 0) ? 0 : 1;
                    if (w == 0) begin m_s0 = imin(m_s0 + 1, WIN); ns = m_s0; end
                    else begin m_s1 = imin(m_s1 + 1, WIN); ns = m_s1; end
                    m_sd = (w == 0) ? 1 : 0;
                    if (ns == WIN) begin
                        m_state = M_OVER; m_wv = 1; m_win = w;
                    end else begin
                        m_state = M_PAUSE; m_pause = 0;
                    end
                end
            end
            M_PAUSE: begin
                m_pause++;
                if (m_pause == PT) enter_serve();
            end
            M_OVER: if (l) begin
                m_s0 = 0; m_s1 = 0; m_wv = 0; m_sd = 0;
                enter_serve();
            end
            default: m_state = M_IDLE;
        endcase
    endtask

    task automatic model_pulse(input bit p0, input bit p1);
        if (m_state == M_RALLY) begin
            if (p0) m_f0 = 1;
            if (p1) m_f1 = 1;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        int lv;
        lv       = imin(m_rally / LT, ML);
        e.run    = (m_state == M_RALLY) ? 1 : 0;
        e.rr     = (m_state == M_RALLY) ? 0 : 1;
        e.sd     = m_sd;
        e.level  = lv;
        e.speed  = imin(1 + lv / 4, 4);
        e.paddle = imax(100 - lv * 9, 25);
        e.s0     = m_s0;
        e.s1     = m_s1;
        e.wv     = m_wv;
        e.win    = m_win;
        e.slot   = slot;
        slot++;
        exp_q.push_back(e);
    endtask

    task automatic check_val(input string nm, input int sl, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (slot %0d): got %0d, expected %0d", nm, sl, act, exp);
        end
    endtask

    // Monitor: after each tick or reset, wait for the registered outputs to
    // settle (speed/paddle lag one clock) and compare with the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            if (tick || reset) begin
                @(negedge clock);
                @(negedge clock);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
                end else begin
                    e = exp_q.pop_front();
                    check_val("run",          e.slot, int'(run),          e.run);
                    check_val("round_reset",  e.slot, int'(round_reset),  e.rr);
                    check_val("serve_dir",    e.slot, int'(serve_dir),    e.sd);
                    check_val("level",        e.slot, int'(level),        e.level);
                    check_val("ball_speed",   e.slot, int'(ball_speed),   e.speed);
                    check_val("paddle_h",     e.slot, int'(paddle_h),     e.paddle);
                    check_val("score_p0",     e.slot, int'(score_p0),     e.s0);
                    check_val("score_p1",     e.slot, int'(score_p1),     e.s1);
                    check_val("winner_valid", e.slot, int'(winner_valid), e.wv);
                    check_val("winner",       e.slot, int'(winner),       e.win);
                end
            end
        end
    end

    // One tick slot: tick cycle, then a gap cycle carrying optional pulses.
    task automatic do_tick(input bit l, input bit p0, input bit p1);
        @(negedge clock);
        tick = 1'b1; launch = l; point_p0 = 1'b0; point_p1 = 1'b0;
        model_tick(l);
        push_exp();
        @(negedge clock);
        tick = 1'b0; launch = 1'b0; point_p0 = p0; point_p1 = p1;
        model_pulse(p0, p1);
        @(negedge clock);
        point_p0 = 1'b0; point_p1 = 1'b0;
    endtask

    // Reset slot with tick, launch and both point inputs driven high.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; tick = 1'b1; launch = 1'b1; point_p0 = 1'b1; point_p1 = 1'b1;
        model_reset();
        push_exp();
        @(negedge clock);
        reset = 1'b0; tick = 1'b0; launch = 1'b0; point_p0 = 1'b0; point_p1 = 1'b0;
        @(negedge clock);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b0, 1'b0, 1'b0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed match walk-through followed by random play.
    initial begin
        bit l, p0, p1;
        int r;
        model_reset();
        do_reset();
        do_tick(1'b0, 1'b0, 1'b0);          // IDLE -> SERVE
        do_tick(1'b1, 1'b0, 1'b1);          // SERVE -> RALLY, p1 scores
        do_tick(1'b0, 1'b0, 1'b0);          // score_p1=1, PAUSE, serve_dir=0
        idle_ticks(PT);                     // back to SERVE
        do_tick(1'b1, 1'b1, 1'b1);          // RALLY, both pulses together
        do_tick(1'b0, 1'b0, 1'b0);          // PAUSE, no score change
        idle_ticks(PT);
        do_tick(1'b1, 1'b0, 1'b0);          // long rally for level saturation
        idle_ticks(39);
        do_tick(1'b0, 1'b1, 1'b0);
        do_tick(1'b0, 1'b0, 1'b0);          // score_p0=1, PAUSE at level 8
        idle_ticks(PT);                     // SERVE, level back to 0
        do_tick(1'b1, 1'b1, 1'b0);
        do_tick(1'b0, 1'b0, 1'b1);          // OVER, winner 0; pulse ignored
        do_tick(1'b0, 1'b0, 1'b0);
        do_tick(1'b1, 1'b0, 1'b0);          // launch clears match, SERVE
        do_tick(1'b1, 1'b0, 1'b1);
        do_tick(1'b0, 1'b0, 1'b0);          // PAUSE
        idle_ticks(10);
        do_reset();                         // reset mid-pause
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                l  = ($urandom_range(0, 3) == 0);
                r  = $urandom_range(0, 99);
                p0 = (r < 6) || (r >= 12 && r < 14);
                p1 = (r >= 6 && r < 14);
                do_tick(l, p0, p1);
            end
        end
        repeat (4) @(negedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_match_sequencer.md
PONG_MATCH_SEQUENCER -- requirements
Module: pong_match_sequencer

Interface
REQ-001 Parameter WIN_SCORE, default 11, points needed to win the match (1..99).
REQ-002 Parameter PAUSE_TICKS, default 100, ticks spent in PAUSE after a point.
REQ-003 Parameter LEVEL_TICKS, default 1024, rally ticks per difficulty level step.
REQ-004 Parameter MAX_LEVEL, default 8, saturation value of level.
REQ-005 Parameters START_SPEED 1, MAX_SPEED 4, PADDLE_MAX 100, PADDLE_MIN 25, PADDLE_STEP 9: ball speed and paddle height limits.
REQ-006 clock  input  1  system clock; all state changes on its rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 tick  input  1  single-cycle game strobe (100 Hz); the FSM and all timers advance only on tick cycles.
REQ-009 launch  input  1  serve request, level-sensitive, sampled on tick.
REQ-010 point_p0 / point_p1  input  1 each  pulse from the datapath, any cycle: ball passed player 1's or player 0's edge; point_p0 credits player 0.
REQ-011 run  output  1  high only in RALLY; datapath moves the ball only while high.
REQ-012 round_reset  output  1  high in IDLE, SERVE, PAUSE and OVER; datapath recentres ball and paddles.
REQ-013 serve_dir  output  1  initial ball x-direction, 1 = toward player 1.
REQ-014 ball_speed  output  3  pixels per tick, START_SPEED..MAX_SPEED.
REQ-015 paddle_h  output  9  paddle height in pixels, PADDLE_MIN..PADDLE_MAX.
REQ-016 level  output  4  current difficulty level, 0..MAX_LEVEL.
REQ-017 score_p0 / score_p1  output  7 each  binary scores.
REQ-018 winner_valid / winner  output  1 each  match over; winning player index.

Function
REQ-019 States IDLE, SERVE, RALLY, PAUSE, OVER; the state register updates only on tick.
REQ-020 IDLE -> SERVE on the next tick.
REQ-021 SERVE -> RALLY on a tick with launch=1; otherwise SERVE is held.
REQ-022 Point events in RALLY are captured into sticky flags on any cycle; flags are consumed and cleared on the next tick; flags are not set in any other state.
REQ-023 RALLY on tick with exactly one flag set: increment that player's score; go to OVER if the new score equals WIN_SCORE, else to PAUSE.
REQ-024 RALLY on tick with both flags set: no score change, serve_dir unchanged, go to PAUSE.
REQ-025 After a scored point, serve_dir points toward the player who conceded.
REQ-026 PAUSE counts PAUSE_TICKS ticks, then goes to SERVE; a point pulse during PAUSE is ignored.
REQ-027 OVER: winner_valid=1 with winner held; on a tick with launch=1, scores, winner_valid and serve_dir are cleared and the FSM goes to SERVE.
REQ-028 Scores saturate at WIN_SCORE and never wrap.
REQ-029 The level timer counts rally ticks; when it reaches LEVEL_TICKS-1, the timer wraps to 0 and level increments, saturating at MAX_LEVEL.
REQ-030 The level timer and level clear on entry to SERVE.
REQ-031 ball_speed = min(START_SPEED + level/4, MAX_SPEED), integer division.
REQ-032 paddle_h = max(PADDLE_MAX - level*PADDLE_STEP, PADDLE_MIN), computed at least 10 bits wide with no underflow.
REQ-033 ball_speed and paddle_h are registered; they update one clock after level changes.
REQ-034 run and round_reset are decoded from the state register and change in the same cycle as the state.

Reset
REQ-035 On reset: state=IDLE, scores=0, level=0, timers=0, flags=0, serve_dir=1, winner_valid=0, winner=0, run=0, round_reset=1, ball_speed=START_SPEED, paddle_h=PADDLE_MAX.
REQ-036 Reset asserted mid-rally or mid-pause overrides tick and point inputs in the same cycle.

Structure
REQ-037 Package pong_pkg holds the state enum and the speed/paddle limit constants shared with the game datapath.
REQ-038 Sub-module pong_tick_timer (tick-enabled counter with clear, terminal-count and wrap) is instantiated twice: once for the pause timer and once for the level timer.
REQ-039 Target size is 120-400 RTL lines, with no multipliers beyond a constant multiply for paddle_h.

Verification
REQ-040 Reset, one tick, then launch=1 on a tick -> IDLE, SERVE, RALLY; run=1, round_reset=0, ball_speed=1, paddle_h=100.
REQ-041 In RALLY, a point_p1 pulse between ticks -> on the next tick score_p1=1, state PAUSE, serve_dir=0; after 100 ticks, state SERVE.
REQ-042 point_p0 and point_p1 in the same cycle -> no score change, PAUSE, serve_dir unchanged.
REQ-043 With LEVEL_TICKS=4, run 40 rally ticks -> level saturates at 8, ball_speed=3, paddle_h=28; re-serve -> level=0, paddle_h=100.
REQ-044 With WIN_SCORE=2, two point_p0 events -> OVER, winner_valid=1, winner=0, score_p0=2; a further pulse is ignored; launch -> scores 0, SERVE.
REQ-045 Assert reset for one cycle mid-PAUSE with point pulses active -> all outputs equal the reset values of REQ-035.
